reg_writeback_ctrl: RTL

Write-back controller that owns the single write port of the 32×32 integer register file. It merges single-cycle ALU results with long-latency load/multiply-divide results through a small result buffer. It keeps a pending-write scoreboard so the issue stage can detect RAW hazards on the two read addresses. It sits between the execute units and the register file, driving that file's `WE`/`ADD_D`/`REG_D` inputs directly.

---
 rtl/reg_writeback_ctrl_if.sv | 37 +++
 rtl/reg_writeback_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/reg_writeback_ctrl_if.sv
// reg_writeback_ctrl_if
//   Bundles the execute-side, issue-side and register-file-side signals of the
//   write-back controller.
//   master : drives ALU / long-latency results, issue info and check addresses
//            (the execute/issue side, or a testbench).
//   slave  : the write-back controller itself; returns LL_READY, HAZ_A/HAZ_B
//            and the registered register-file write port WE/ADD_D/REG_D.
interface reg_writeback_ctrl_if;
  logic        ALU_WE;
  logic [4:0]  ALU_RD;
  logic [31:0] ALU_DATA;
  logic        LL_VALID;
  logic [4:0]  LL_RD;
  logic [31:0] LL_DATA;
  logic        LL_READY;
  logic        ISS_VALID;
  logic [4:0]  ISS_RD;
  logic [4:0]  CHK_A;
  logic [4:0]  CHK_B;
  logic        HAZ_A;
  logic        HAZ_B;
  logic        WE;
  logic [4:0]  ADD_D;
  logic [31:0] REG_D;

  modport master (
    output ALU_WE, ALU_RD, ALU_DATA, LL_VALID, LL_RD, LL_DATA,
           ISS_VALID, ISS_RD, CHK_A, CHK_B,
    input  LL_READY, HAZ_A, HAZ_B, WE, ADD_D, REG_D
  );

  modport slave (
    input  ALU_WE, ALU_RD, ALU_DATA, LL_VALID, LL_RD, LL_DATA,
           ISS_VALID, ISS_RD, CHK_A, CHK_B,
    output LL_READY, HAZ_A, HAZ_B, WE, ADD_D, REG_D
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl
//   Owns the single write port of the 32x32 register file. ALU results take
//   the write slot directly; long-latency results queue in a DEPTH-entry FIFO
//   and drain whenever the ALU does not claim the slot. A pending-write
//   scoreboard plus the in-flight write drives the RAW hazard outputs.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - slave side of reg_writeback_ctrl_if (results in, LL_READY,
//          HAZ_A/HAZ_B, registered WE/ADD_D/REG_D out)
module reg_writeback_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RST,
  reg_writeback_ctrl_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][4:0]  buf_rd_q, buf_rd_d;
  logic [DEPTH-1:0][31:0] buf_data_q, buf_data_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW:0]            cnt_q, cnt_d;
  logic [31:0]            pend_q, pend_d;
  logic                   we_q, we_d;
  logic [4:0]             add_q, add_d;
  logic [31:0]            reg_q, reg_d;

  logic alu_wr, ll_ready, push, pop;

  // Writes to x0 never occupy the slot, so the buffer can drain that cycle.
  assign alu_wr   = bus.ALU_WE && (bus.ALU_RD != 5'd0);
  // Depends on state only: a full buffer refuses even when it pops.
  assign ll_ready = cnt_q < (PW+1)'(DEPTH);
  assign pop      = !alu_wr && (cnt_q != '0);
  // x0 results are accepted but dropped.
  assign push     = bus.LL_VALID && ll_ready && (bus.LL_RD != 5'd0);

  always_comb begin
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_d     = pend_q;
    we_d       = 1'b0;
    add_d      = add_q;
    reg_d      = reg_q;

    if (alu_wr) begin
      we_d  = 1'b1;
      add_d = bus.ALU_RD;
      reg_d = bus.ALU_DATA;
    end else if (pop) begin
      we_d                     = 1'b1;
      add_d                    = buf_rd_q[rd_ptr_q];
      reg_d                    = buf_data_q[rd_ptr_q];
      rd_ptr_d                 = rd_ptr_q + 1'b1;
      pend_d[buf_rd_q[rd_ptr_q]] = 1'b0;
    end

    if (push) begin
      buf_rd_d[wr_ptr_q]   = bus.LL_RD;
      buf_data_d[wr_ptr_q] = bus.LL_DATA;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end

    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

    // Set after clear so a same-cycle issue to the popped register wins.
    if (bus.ISS_VALID && (bus.ISS_RD != 5'd0)) pend_d[bus.ISS_RD] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      we_q       <= 1'b0;
      add_q      <= 5'd0;
      reg_q      <= 32'd0;
    end else begin
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      we_q       <= we_d;
      add_q      <= add_d;
      reg_q      <= reg_d;
    end
  end

  // In-flight term: the file only updates at the next edge, so a read of the
  // register being written this cycle still sees stale data.
  assign bus.HAZ_A    = (bus.CHK_A != 5'd0) &&
                        (pend_q[bus.CHK_A] || (we_q && (add_q == bus.CHK_A)));
  assign bus.HAZ_B    = (bus.CHK_B != 5'd0) &&
                        (pend_q[bus.CHK_B] || (we_q && (add_q == bus.CHK_B)));
  assign bus.LL_READY = ll_ready;
  assign bus.WE       = we_q;
  assign bus.ADD_D    = add_q;
  assign bus.REG_D    = reg_q;
endmodule
